executor: RTL and testbench

EXECUTOR -- requirements
Module: executor

---
 rtl/executor_pkg.sv | 52 +++++
 rtl/executor_alu.sv | 29 ++
 rtl/executor.sv | 208 ++++++++++++++++++++
 tb/tb_executor.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/executor_pkg.sv
// ============================================================================
//  Module      : executor_pkg
//  Description : Opcodes, action word layout and bus-size defaults shared by
//                the executor and its ALU.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif
`ifndef DATA_BUS
`define DATA_BUS 32
`endif
`ifndef MAX_VAL_LEN
`define MAX_VAL_LEN 16
`endif
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 64
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 16
`endif

package executor_pkg;

   localparam int ACT_BYTES = 4;

   typedef enum logic [7:0] {
      OP_END     = 8'd0,
      OP_SET     = 8'd1,
      OP_ADD     = 8'd2,
      OP_DEC_SAT = 8'd3,
      OP_FWD     = 8'd4,
      OP_DROP    = 8'd5
   } opcode_e;

   // op is kept as a raw byte so undefined opcodes survive to the decoder.
   typedef struct packed {
      logic [7:0] op;
      logic [3:0] hdr_id;
      logic [7:0] off;
      logic [7:0] imm;
   } action_t;

   function automatic logic [7:0] dec_sat(input logic [7:0] v);
      return (v == 8'd0) ? 8'd0 : v - 8'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/executor_alu.sv
// ============================================================================
//  Module      : executor_alu
//  Description : Combinational byte datapath for SET, ADD and DEC_SAT.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module executor_alu
   import executor_pkg::*;
(
   input  logic [7:0] op_i,
   input  logic [7:0] old_i,
   input  logic [7:0] imm_i,
   output logic [7:0] new_o
);

   always_comb begin
      new_o = old_i;
      case (op_i)
         OP_SET:     new_o = imm_i;
         OP_ADD:     new_o = old_i + imm_i;
         OP_DEC_SAT: new_o = dec_sat(old_i);
         default:    new_o = old_i;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/executor.sv
// ============================================================================
//  Module      : executor
//  Description : Applies a flow-table action list to a packet header, one
//                action per cycle. Optional macro EXECUTOR_BOUNDS_CHECK_EN
//                rejects out-of-range byte targets instead of wrapping them.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif
`ifndef DATA_BUS
`define DATA_BUS 32
`endif
`ifndef MAX_VAL_LEN
`define MAX_VAL_LEN 16
`endif
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 64
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 16
`endif

module executor
   import executor_pkg::*;
(
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       start_i,
   input  logic                                       is_match_i,
   input  logic [`MAX_VAL_LEN-1:0][`BYTE_BUS-1:0]     flow_val_i,
   input  logic [`HDR_MAX_LEN-1:0][`BYTE_BUS-1:0]     pkt_hdr_i,
   input  logic [`NUM_HEADERS-1:0][`DATA_BUS-1:0]     parsed_hdrs_i,
   input  logic                                       mod_start_i,
   input  logic [7:0]                                 mod_default_port_i,
   input  logic                                       mod_miss_drop_i,
   output logic                                       ready_o,
   output logic [`HDR_MAX_LEN-1:0][`BYTE_BUS-1:0]     pkt_hdr_o,
   output logic [7:0]                                 port_o,
   output logic                                       drop_o,
   output logic                                       err_o
);

   localparam int HDR_LEN = `HDR_MAX_LEN;
   localparam int NUM_ACT = `MAX_VAL_LEN / ACT_BYTES;
   localparam int IDX_W   = (NUM_ACT > 1) ? $clog2(NUM_ACT) : 1;
   localparam int ADDR_W  = $clog2(HDR_LEN);

   typedef enum logic [0:0] {
      FREE = 1'b0,
      EXEC = 1'b1
   } state_e;

   state_e                                    state_q, state_d;
   logic [HDR_LEN-1:0][`BYTE_BUS-1:0]         hdr_q, hdr_d;
   action_t [NUM_ACT-1:0]                     acts_q, acts_d;
   logic [`NUM_HEADERS-1:0][`DATA_BUS-1:0]    offs_q, offs_d;
   logic [IDX_W-1:0]                          idx_q, idx_d;
   logic [7:0]                                port_q, port_d;
   logic [7:0]                                def_port_q, def_port_d;
   logic                                      miss_drop_q, miss_drop_d;
   logic                                      drop_q, drop_d;
   logic                                      err_q, err_d;
   logic                                      ready_q, ready_d;

   action_t [NUM_ACT-1:0]                     act_in;
   logic [NUM_ACT-1:0]                        unused_hdr_id_hi;

   for (genvar a = 0; a < NUM_ACT; a++) begin : g_decode
      assign act_in[a].op      = flow_val_i[ACT_BYTES*a];
      assign act_in[a].hdr_id  = flow_val_i[ACT_BYTES*a+1][3:0];
      assign act_in[a].off     = flow_val_i[ACT_BYTES*a+2];
      assign act_in[a].imm     = flow_val_i[ACT_BYTES*a+3];
      assign unused_hdr_id_hi[a] = |flow_val_i[ACT_BYTES*a+1][7:4];
   end

   action_t            cur;
   logic [31:0]        target;
   logic [ADDR_W-1:0]  addr;
   logic               oob;
   logic [7:0]         alu_byte;
   logic               last;
   logic               done;

   assign cur    = acts_q[idx_q];
   assign target = 32'(offs_q[cur.hdr_id]) + 32'(cur.off);
   assign addr   = target[ADDR_W-1:0];
   assign last   = (idx_q == IDX_W'(NUM_ACT - 1));

`ifdef EXECUTOR_BOUNDS_CHECK_EN
   assign oob = (target >= 32'(HDR_LEN));
`else
   // Upper target bits are intentionally dropped so addresses wrap.
   logic unused_target_hi;
   assign oob              = 1'b0;
   assign unused_target_hi = |target[31:ADDR_W];
`endif

   executor_alu u_alu (
      .op_i  (cur.op),
      .old_i (hdr_q[addr]),
      .imm_i (cur.imm),
      .new_o (alu_byte)
   );

   always_comb begin
      state_d     = state_q;
      hdr_d       = hdr_q;
      acts_d      = acts_q;
      offs_d      = offs_q;
      idx_d       = idx_q;
      port_d      = port_q;
      def_port_d  = def_port_q;
      miss_drop_d = miss_drop_q;
      drop_d      = drop_q;
      err_d       = err_q;
      ready_d     = 1'b0;
      done        = 1'b0;

      case (state_q)
         FREE: begin
            if (mod_start_i) begin
               def_port_d  = mod_default_port_i;
               miss_drop_d = mod_miss_drop_i;
            end else if (start_i) begin
               hdr_d  = pkt_hdr_i;
               port_d = def_port_q;
               err_d  = 1'b0;
               if (is_match_i) begin
                  drop_d  = 1'b0;
                  acts_d  = act_in;
                  offs_d  = parsed_hdrs_i;
                  idx_d   = '0;
                  state_d = EXEC;
               end else begin
                  drop_d  = miss_drop_q;
                  ready_d = 1'b1;
               end
            end
         end

         EXEC: begin
            case (cur.op)
               OP_END: done = 1'b1;
               OP_SET, OP_ADD, OP_DEC_SAT: begin
                  if (oob) err_d = 1'b1;
                  else     hdr_d[addr] = alu_byte;
               end
               OP_FWD:  port_d = cur.imm;
               OP_DROP: begin
                  drop_d = 1'b1;
                  done   = 1'b1;
               end
               default: err_d = 1'b1;
            endcase

            if (done || last) begin
               ready_d = 1'b1;
               idx_d   = '0;
               state_d = FREE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         default: state_d = FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FREE;
         hdr_q       <= '0;
         acts_q      <= '0;
         offs_q      <= '0;
         idx_q       <= '0;
         port_q      <= '0;
         def_port_q  <= '0;
         miss_drop_q <= 1'b0;
         drop_q      <= 1'b0;
         err_q       <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_q       <= hdr_d;
         acts_q      <= acts_d;
         offs_q      <= offs_d;
         idx_q       <= idx_d;
         port_q      <= port_d;
         def_port_q  <= def_port_d;
         miss_drop_q <= miss_drop_d;
         drop_q      <= drop_d;
         err_q       <= err_d;
         ready_q     <= ready_d;
      end
   end

   assign ready_o   = ready_q;
   assign pkt_hdr_o = hdr_q;
   assign port_o    = port_q;
   assign drop_o    = drop_q;
   assign err_o     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_executor.sv
// ============================================================================
//  Module      : tb_executor
//  Description : Directed self-checking bench for the executor.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif
`ifndef DATA_BUS
`define DATA_BUS 32
`endif
`ifndef MAX_VAL_LEN
`define MAX_VAL_LEN 16
`endif
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 64
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 16
`endif

module tb_executor;

   localparam int HL = `HDR_MAX_LEN;
   localparam int VL = `MAX_VAL_LEN;
   localparam int NH = `NUM_HEADERS;
   localparam int DB = `DATA_BUS;

   typedef logic [HL-1:0][7:0] hdr_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start_i = 1'b0;
   logic                 is_match_i = 1'b0;
   logic [VL-1:0][7:0]   flow_val_i = '0;
   hdr_t                 pkt_hdr_i = '0;
   logic [NH-1:0][DB-1:0] parsed_hdrs_i = '0;
   logic                 mod_start_i = 1'b0;
   logic [7:0]           mod_default_port_i = '0;
   logic                 mod_miss_drop_i = 1'b0;
   logic                 ready_o;
   hdr_t                 pkt_hdr_o;
   logic [7:0]           port_o;
   logic                 drop_o;
   logic                 err_o;

   int checks = 0;
   int errors = 0;

   executor dut (
      .clk                (clk),
      .rst                (rst),
      .start_i            (start_i),
      .is_match_i         (is_match_i),
      .flow_val_i         (flow_val_i),
      .pkt_hdr_i          (pkt_hdr_i),
      .parsed_hdrs_i      (parsed_hdrs_i),
      .mod_start_i        (mod_start_i),
      .mod_default_port_i (mod_default_port_i),
      .mod_miss_drop_i    (mod_miss_drop_i),
      .ready_o            (ready_o),
      .pkt_hdr_o          (pkt_hdr_o),
      .port_o             (port_o),
      .drop_o             (drop_o),
      .err_o              (err_o)
   );

   always #5 clk = ~clk;

   function automatic hdr_t pattern(input int seed);
      hdr_t p;
      for (int i = 0; i < HL; i++) p[i] = 8'(i * 7 + seed);
      return p;
   endfunction

   task automatic set_act(input int i, input logic [7:0] op, input logic [7:0] hid,
                          input logic [7:0] off, input logic [7:0] imm);
      flow_val_i[4*i]   = op;
      flow_val_i[4*i+1] = hid;
      flow_val_i[4*i+2] = off;
      flow_val_i[4*i+3] = imm;
   endtask

   task automatic configure(input logic [7:0] port, input logic miss_drop);
      @(negedge clk);
      mod_start_i        = 1'b1;
      mod_default_port_i = port;
      mod_miss_drop_i    = miss_drop;
      @(negedge clk);
      mod_start_i        = 1'b0;
   endtask

   // lat = number of edges after the start-sampling edge until ready_o is seen.
   task automatic run_op(input logic hit, input logic disturb, output int lat);
      @(negedge clk);
      start_i    = 1'b1;
      is_match_i = hit;
      @(posedge clk); #1;
      start_i    = 1'b0;
      is_match_i = 1'b0;
      lat = 0;
      while (ready_o !== 1'b1 && lat < 20) begin
         if (disturb && lat == 0) begin
            start_i            = 1'b1;
            is_match_i         = 1'b0;
            mod_start_i        = 1'b1;
            mod_default_port_i = 8'h55;
            mod_miss_drop_i    = 1'b0;
            pkt_hdr_i          = ~pkt_hdr_i;
            flow_val_i         = {VL{8'h05}};
         end
         @(posedge clk); #1;
         lat++;
         if (disturb && lat == 1) begin
            start_i     = 1'b0;
            mod_start_i = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
      checks++; if (port_o !== 8'h00) begin errors++; $display("FAIL reset_port: got %h expected 00", port_o); end
      checks++; if (drop_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_flags: got drop=%b err=%b expected 0/0", drop_o, err_o); end
      checks++; if (pkt_hdr_o !== hdr_t'(0)) begin errors++; $display("FAIL reset_hdr: got %h expected 0", pkt_hdr_o); end
      rst = 1'b0;
   endtask

   task automatic test_miss;
      int lat;
      // start_i during a config write must be ignored
      @(negedge clk);
      mod_start_i = 1'b1; mod_default_port_i = 8'd3; mod_miss_drop_i = 1'b0;
      start_i = 1'b1; is_match_i = 1'b0; pkt_hdr_i = pattern(99);
      @(posedge clk); #1;
      mod_start_i = 1'b0; start_i = 1'b0;
      checks++; if (ready_o !== 1'b0 || pkt_hdr_o !== hdr_t'(0)) begin errors++; $display("FAIL cfg_ignores_start: got ready=%b hdr0=%h expected 0/00", ready_o, pkt_hdr_o[0]); end

      pkt_hdr_i = pattern(1);
      run_op(1'b0, 1'b0, lat);
      checks++; if (lat !== 0) begin errors++; $display("FAIL miss_latency: got %0d expected 0", lat); end
      checks++; if (port_o !== 8'd3 || drop_o !== 1'b0) begin errors++; $display("FAIL miss_verdict: got port=%h drop=%b expected 03/0", port_o, drop_o); end
      checks++; if (pkt_hdr_o !== pattern(1)) begin errors++; $display("FAIL miss_hdr: got %h expected %h", pkt_hdr_o, pattern(1)); end
      @(posedge clk); #1;
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL miss_ready_pulse: got %b expected 0", ready_o); end

      configure(8'd3, 1'b1);
      pkt_hdr_i = pattern(2);
      run_op(1'b0, 1'b0, lat);
      checks++; if (lat !== 0 || drop_o !== 1'b1 || port_o !== 8'd3) begin errors++; $display("FAIL miss_drop: got lat=%0d drop=%b port=%h expected 0/1/03", lat, drop_o, port_o); end
   endtask

   task automatic test_set_fwd;
      int   lat;
      hdr_t exp;
      parsed_hdrs_i    = '0;
      parsed_hdrs_i[1] = 32'd14;
      flow_val_i = '0;
      set_act(0, 8'd1, 8'd1, 8'd8, 8'h40);
      set_act(1, 8'd4, 8'd0, 8'd0, 8'd7);
      set_act(2, 8'd0, 8'd0, 8'd0, 8'd0);
      pkt_hdr_i = pattern(5);
      exp = pattern(5); exp[22] = 8'h40;
      run_op(1'b1, 1'b1, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL setfwd_latency: got %0d expected 3", lat); end
      checks++; if (pkt_hdr_o !== exp) begin errors++; $display("FAIL setfwd_hdr: got %h expected %h", pkt_hdr_o, exp); end
      checks++; if (port_o !== 8'd7 || drop_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL setfwd_verdict: got port=%h drop=%b err=%b expected 07/0/0", port_o, drop_o, err_o); end
      repeat (2) @(posedge clk); #1;
      checks++; if (ready_o !== 1'b0 || port_o !== 8'd7 || pkt_hdr_o !== exp) begin errors++; $display("FAIL setfwd_hold: got ready=%b port=%h expected 0/07", ready_o, port_o); end

      // config write attempted during EXEC must not have landed
      pkt_hdr_i = pattern(6);
      run_op(1'b0, 1'b0, lat);
      checks++; if (port_o !== 8'd3 || drop_o !== 1'b1) begin errors++; $display("FAIL exec_ignores_cfg: got port=%h drop=%b expected 03/1", port_o, drop_o); end
   endtask

   task automatic test_alu_drop;
      int   lat;
      hdr_t exp;
      parsed_hdrs_i = '0;
      flow_val_i = '0;
      set_act(0, 8'd2, 8'd0, 8'd10, 8'h10);
      set_act(1, 8'd3, 8'd0, 8'd11, 8'h00);
      set_act(2, 8'd5, 8'd0, 8'd0,  8'h00);
      set_act(3, 8'd1, 8'd0, 8'd12, 8'h55);
      pkt_hdr_i = pattern(2); pkt_hdr_i[10] = 8'hF8; pkt_hdr_i[11] = 8'h00;
      exp = pkt_hdr_i; exp[10] = 8'h08;
      run_op(1'b1, 1'b0, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL drop_latency: got %0d expected 3", lat); end
      checks++; if (pkt_hdr_o !== exp) begin errors++; $display("FAIL drop_hdr: got %h expected %h", pkt_hdr_o, exp); end
      checks++; if (drop_o !== 1'b1 || err_o !== 1'b0 || port_o !== 8'd3) begin errors++; $display("FAIL drop_verdict: got drop=%b err=%b port=%h expected 1/0/03", drop_o, err_o, port_o); end
   endtask

   task automatic test_full_list;
      int   lat;
      hdr_t exp;
      parsed_hdrs_i    = '0;
      parsed_hdrs_i[2] = 32'd16;
      flow_val_i = '0;
      set_act(0, 8'd1, 8'd2, 8'd1, 8'hAA);
      set_act(1, 8'd4, 8'd0, 8'd0, 8'd9);
      set_act(2, 8'd4, 8'd0, 8'd0, 8'd11);
      set_act(3, 8'd3, 8'd2, 8'd4, 8'h00);
      pkt_hdr_i = pattern(3); pkt_hdr_i[20] = 8'h05;
      exp = pkt_hdr_i; exp[17] = 8'hAA; exp[20] = 8'h04;
      run_op(1'b1, 1'b0, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL full_latency: got %0d expected 4", lat); end
      checks++; if (pkt_hdr_o !== exp) begin errors++; $display("FAIL full_hdr: got %h expected %h", pkt_hdr_o, exp); end
      checks++; if (port_o !== 8'd11 || drop_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL full_verdict: got port=%h drop=%b err=%b expected 0b/0/0", port_o, drop_o, err_o); end
   endtask

   task automatic test_bad_opcode;
      int lat;
      flow_val_i = '0;
      set_act(0, 8'd9, 8'd0, 8'd3, 8'h77);
      set_act(1, 8'd0, 8'd0, 8'd0, 8'h00);
      pkt_hdr_i = pattern(4);
      run_op(1'b1, 1'b0, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL badop_latency: got %0d expected 2", lat); end
      checks++; if (err_o !== 1'b1 || pkt_hdr_o !== pattern(4)) begin errors++; $display("FAIL badop_result: got err=%b hdr=%h expected 1/%h", err_o, pkt_hdr_o, pattern(4)); end

      flow_val_i = '0;
      pkt_hdr_i  = pattern(7);
      run_op(1'b1, 1'b0, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL end0_latency: got %0d expected 1", lat); end
      checks++; if (pkt_hdr_o !== pattern(7) || port_o !== 8'd3 || err_o !== 1'b0) begin errors++; $display("FAIL end0_result: got port=%h err=%b expected 03/0", port_o, err_o); end
   endtask

   task automatic test_bounds;
      int         lat;
      hdr_t       exp;
      logic       exp_err;
      logic [7:0] oob_off;
      oob_off = 8'(HL + 2);
      parsed_hdrs_i = '0;
      flow_val_i = '0;
      set_act(0, 8'd1, 8'd0, oob_off, 8'hAB);
      set_act(1, 8'd0, 8'd0, 8'd0, 8'h00);
      pkt_hdr_i = pattern(8);
      exp = pattern(8);
`ifdef EXECUTOR_BOUNDS_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
      exp[2]  = 8'hAB;
`endif
      run_op(1'b1, 1'b0, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL bounds_latency: got %0d expected 2", lat); end
      checks++; if (pkt_hdr_o !== exp || err_o !== exp_err) begin errors++; $display("FAIL bounds_result: got err=%b hdr=%h expected %b/%h", err_o, pkt_hdr_o, exp_err, exp); end
   endtask

   task automatic test_reset_mid_exec;
      int lat;
      int seen;
      parsed_hdrs_i = '0;
      flow_val_i = '0;
      for (int i = 0; i < VL / 4; i++) set_act(i, 8'd1, 8'd0, 8'(i), 8'hEE);
      pkt_hdr_i = pattern(9);
      @(negedge clk);
      start_i = 1'b1; is_match_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0; is_match_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (ready_o === 1'b1) seen++;
         @(posedge clk); #1;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_ready: got %0d pulses expected 0", seen); end

      pkt_hdr_i = pattern(10);
      run_op(1'b0, 1'b0, lat);
      checks++; if (lat !== 0) begin errors++; $display("FAIL rst_miss_latency: got %0d expected 0", lat); end
      checks++; if (pkt_hdr_o !== pattern(10) || port_o !== 8'd0 || drop_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL rst_miss_result: got port=%h drop=%b err=%b expected 00/0/0", port_o, drop_o, err_o); end
   endtask

   initial begin
      test_reset;
      test_miss;
      test_set_fwd;
      test_alu_drop;
      test_full_list;
      test_bad_opcode;
      test_bounds;
      test_reset_mid_exec;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
